// File: rtl/f_sweep_ctrl.sv
// Sweeps a 3-input function block through vectors 000..111, holds each for SETTLE
// cycles, captures the block's output and compares it against an expected truth table.
//
// state     | meaning
// ST_IDLE   | waiting for start; results and last vector held
// ST_SETTLE | vector idx driven, settle down-counter running
// ST_SAMPLE | one cycle; s_in captured and compared at the leaving edge
// ST_FINISH | one-cycle done pulse, results valid
module f_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_expected,
  input  logic       i_s_in,
  output logic       o_a_out,
  output logic       o_b_out,
  output logic       o_c_out,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_captured,
  output logic [3:0] o_mismatch_count,
  output logic [2:0] o_first_fail_idx
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_exp;
  logic [7:0] r_captured;
  logic [3:0] r_mm;
  logic [2:0] r_ffi;
  logic       r_pass;
  logic       w_miss;

  assign w_miss = (i_s_in != r_exp[r_idx]);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_start) w_next = ST_SETTLE;
      ST_SETTLE: begin
        o_busy = 1'b1;
        if (r_cnt == 4'd1) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        o_busy = 1'b1;
        w_next = (r_idx == 3'd7) ? ST_FINISH : ST_SETTLE;
      end
      ST_FINISH: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default:   w_next = ST_IDLE;
    endcase
  end

  // idx is not advanced past 7 so a/b/c keep showing the last vector after a sweep
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_exp      <= '0;
      r_captured <= '0;
      r_mm       <= '0;
      r_ffi      <= '0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_idx      <= '0;
            r_cnt      <= SETTLE_W;
            r_exp      <= i_expected;
            r_captured <= '0;
            r_mm       <= '0;
            r_ffi      <= '0;
            r_pass     <= 1'b0;
          end
        end
        ST_SETTLE: r_cnt <= r_cnt - 4'd1;
        ST_SAMPLE: begin
          r_captured[r_idx] <= i_s_in;
          if (w_miss) begin
            r_mm <= r_mm + 4'd1;
            if (r_mm == 4'd0) r_ffi <= r_idx;
          end
          if (r_idx == 3'd7) begin
            r_pass <= (r_mm == 4'd0) && !w_miss;
          end else begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= SETTLE_W;
          end
        end
        default: ;
      endcase
    end
  end

  assign {o_a_out, o_b_out, o_c_out} = r_idx;
  assign o_pass           = r_pass;
  assign o_captured       = r_captured;
  assign o_mismatch_count = r_mm;
  assign o_first_fail_idx = r_ffi;

endmodule
